// File: rtl/game_rng_pkg.sv
// Shared types and helpers for the game_rng random source: FSM states,
// default feedback mask / seed, and the Galois LFSR step used by RTL and models.
package game_rng_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEF_TAPS = 32'h0000_B400;
  localparam logic [31:0] DEF_SEED = 32'h0000_ACE1;

  // Right-shifting Galois step; narrower LFSRs pass zero-extended state and taps.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s, input logic [31:0] taps);
    if (s[0]) begin
      lfsr_step = (s >> 1) ^ taps;
    end else begin
      lfsr_step = s >> 1;
    end
  endfunction

endpackage

// File: rtl/game_rng_lfsr_core.sv
// Free-running Galois LFSR with zero guard and optional button entropy mixing.
// Mixing is compiled in only when GAME_RNG_ENTROPY_EN is defined.
module lfsr_core
  import game_rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_lsb
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_cnt;
  logic             r_btn_q;
  logic [WIDTH-1:0] w_step;
  logic [WIDTH-1:0] w_mix;
  logic [WIDTH-1:0] w_next;

  assign w_step = WIDTH'(lfsr_step(32'(r_state), 32'(TAPS)));

`ifdef GAME_RNG_ENTROPY_EN
  logic w_edge;
  assign w_edge = i_button & ~r_btn_q;

  // A fresh button press folds the free-running counter into the next state.
  always_comb begin
    if (w_edge) begin
      w_mix = w_step ^ r_cnt;
    end else begin
      w_mix = w_step;
    end
  end
`else
  logic w_unused;
  assign w_unused = ^{r_cnt, r_btn_q};
  assign w_mix    = w_step;
`endif

  // The all-zero state would lock the LFSR, so it is replaced by the seed.
  always_comb begin
    if (w_mix == {WIDTH{1'b0}}) begin
      w_next = SEED;
    end else begin
      w_next = w_mix;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= SEED;
      r_cnt   <= {WIDTH{1'b0}};
      r_btn_q <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= r_cnt + WIDTH'(1);
      r_btn_q <= i_button;
    end
  end

  assign o_lsb = r_state[0];

endmodule

// File: rtl/game_rng.sv
// Random word source for the Dino game: collects OUT_W LFSR bits per request.
// Define GAME_RNG_ENTROPY_EN to mix button timing into the LFSR state.
module game_rng
  import game_rng_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter int               OUT_W = 5,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEF_TAPS),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(DEF_SEED)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic             req,
  output logic             valid,
  output logic             busy,
  output logic [OUT_W-1:0] rnd_out
);

  localparam int               IDX_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_W - 1);

  state_e           r_fsm;
  state_e           w_fsm_next;
  logic [IDX_W-1:0] r_idx;
  logic [OUT_W-1:0] r_acc;
  logic [OUT_W-1:0] w_acc_next;
  logic [OUT_W-1:0] r_rnd;
  logic             r_valid;
  logic             r_busy;
  logic             w_lsb;
  logic             w_last;

  lfsr_core #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS),
    .SEED  (SEED)
  ) u_core (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_button (button),
    .o_lsb    (w_lsb)
  );

  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fsm <= IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  // The bit sampled is the pre-step LSB, so any mix this cycle does not affect it.
  always_comb begin
    w_fsm_next        = r_fsm;
    w_acc_next        = r_acc;
    w_acc_next[r_idx] = w_lsb;
    case (r_fsm)
      IDLE: begin
        if (req) begin
          w_fsm_next = DRAW;
        end else begin
          w_fsm_next = IDLE;
        end
      end
      DRAW: begin
        if (w_last) begin
          w_fsm_next = DONE;
        end else begin
          w_fsm_next = DRAW;
        end
      end
      DONE:    w_fsm_next = IDLE;
      default: w_fsm_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_idx   <= {IDX_W{1'b0}};
      r_acc   <= {OUT_W{1'b0}};
      r_rnd   <= {OUT_W{1'b0}};
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_busy  <= (w_fsm_next == DRAW);
      r_valid <= (r_fsm == DRAW) && w_last;
      case (r_fsm)
        IDLE: begin
          if (req) begin
            r_idx <= {IDX_W{1'b0}};
            r_acc <= {OUT_W{1'b0}};
          end
        end
        DRAW: begin
          r_idx <= r_idx + IDX_W'(1);
          r_acc <= w_acc_next;
          if (w_last) begin
            r_rnd <= w_acc_next;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign valid   = r_valid;
  assign busy    = r_busy;
  assign rnd_out = r_rnd;

endmodule
